// File: rtl/opl3_host_if.sv
// opl3_host_if - host-side front end of the OPL3 core.
//
// Decodes CPU I/O writes at base+0..3 into a latched register address/bank
// and register-data writes, queues the writes in a small FIFO, and hands
// them one at a time to the register file via valid/ready.  A programmable
// gap is enforced between accepted transfers.  Status reads return the
// timer flags.
//
// Ports:
//   clk                clock
//   ic_n               synchronous active-low reset
//   host_address[1:0]  port offset: 0/2 address (bank0/bank1), 1/3 data
//   host_wr, host_rd   single-cycle write / read strobes
//   host_din[7:0]      write data
//   host_dout[7:0]     registered read data
//   irq_n, ft1, ft2    timer IRQ (active low) and timer flags
//   opl3_reg_wr        {valid, bank_num, address, data} to the register file
//   opl3_reg_wr_ready  downstream accept
//   fifo_overflow      sticky: a data write was dropped

package opl3_host_if_pkg;
  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;
endpackage

module opl3_host_if
  import opl3_host_if_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_GAP    = 2
) (
  input  logic         clk,
  input  logic         ic_n,
  input  logic [1:0]   host_address,
  input  logic         host_wr,
  input  logic         host_rd,
  input  logic [7:0]   host_din,
  output logic [7:0]   host_dout,
  input  logic         irq_n,
  input  logic         ft1,
  input  logic         ft2,
  output opl3_reg_wr_t opl3_reg_wr,
  input  logic         opl3_reg_wr_ready,
  output logic         fifo_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int GW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam logic [PW:0]   PTR_ONE  = (PW + 1)'(1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP);

  // entry layout: {bank, address, data}
  logic [16:0]   mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    addr_q;
  logic          bank_q;

  logic empty;
  logic full;
  logic valid;
  logic pop;
  logic push_req;
  logic push;
  logic [16:0] head;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) &&
                    (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign valid    = !empty && (gap_cnt == '0);
  assign pop      = valid && opl3_reg_wr_ready;
  assign push_req = host_wr && host_address[0];
  // a full FIFO still takes the write when the head leaves in the same cycle
  assign push     = push_req && (!full || pop);
  assign head     = mem[rd_ptr[PW-1:0]];

  assign opl3_reg_wr.valid    = valid;
  assign opl3_reg_wr.bank_num = head[16];
  assign opl3_reg_wr.address  = head[15:8];
  assign opl3_reg_wr.data     = head[7:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= {bank_q, addr_q, host_din};
    end
  end

  always_ff @(posedge clk) begin
    if (!ic_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      gap_cnt       <= '0;
      addr_q        <= 8'h00;
      bank_q        <= 1'b0;
      host_dout     <= 8'h00;
      fifo_overflow <= 1'b0;
    end else begin
      if (host_wr && !host_address[0]) begin
        addr_q <= host_din;
        bank_q <= host_address[1];
      end

      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else if (push_req) begin
        fifo_overflow <= 1'b1;
      end

      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        gap_cnt <= GAP_LOAD;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_ONE;
      end

      if (host_rd) begin
        host_dout <= (host_address == 2'd0) ? {~irq_n, ft1, ft2, 5'b00000} : 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_opl3_host_if.sv
// Directed bench for opl3_host_if (FIFO_DEPTH=4, MIN_GAP=2).
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, i.e. they reflect the state after that edge.

module tb_opl3_host_if;
  import opl3_host_if_pkg::*;

  logic         clk;
  logic         ic_n;
  logic [1:0]   host_address;
  logic         host_wr;
  logic         host_rd;
  logic [7:0]   host_din;
  logic [7:0]   host_dout;
  logic         irq_n;
  logic         ft1;
  logic         ft2;
  opl3_reg_wr_t q;
  logic         ready;
  logic         fifo_overflow;

  int total = 0;
  int bad   = 0;

  opl3_host_if #(.FIFO_DEPTH(4), .MIN_GAP(2)) dut (
    .clk              (clk),
    .ic_n             (ic_n),
    .host_address     (host_address),
    .host_wr          (host_wr),
    .host_rd          (host_rd),
    .host_din         (host_din),
    .host_dout        (host_dout),
    .irq_n            (irq_n),
    .ft1              (ft1),
    .ft2              (ft2),
    .opl3_reg_wr      (q),
    .opl3_reg_wr_ready(ready),
    .fifo_overflow    (fifo_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    host_address = a;
    host_din     = d;
    host_wr      = 1'b1;
    tick();
    host_wr      = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] a);
    host_address = a;
    host_rd      = 1'b1;
    tick();
    host_rd      = 1'b0;
  endtask

  task automatic do_reset();
    ic_n = 1'b0;
    tick();
    ic_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (q.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", q.valid); end
    total++; if (host_dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", host_dout); end
    total++; if (fifo_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", fifo_overflow); end
  endtask

  task automatic test_single();
    ready = 1'b1;
    host_write(2'd0, 8'h20);
    total++; if (q.valid !== 1'b0) begin bad++; $display("FAIL addr_no_push: got valid %b want 0", q.valid); end
    host_write(2'd1, 8'h55);
    total++; if ({q.valid, q.bank_num, q.address, q.data} !== {1'b1, 1'b0, 8'h20, 8'h55})
      begin bad++; $display("FAIL single_out: got %b/%b/%h/%h want 1/0/20/55", q.valid, q.bank_num, q.address, q.data); end
    tick();
    total++; if (q.valid !== 1'b0) begin bad++; $display("FAIL single_after: got valid %b want 0", q.valid); end
    tick(); tick(); tick();
  endtask

  task automatic test_order_gap();
    ready = 1'b1;
    host_write(2'd2, 8'h05);
    host_write(2'd3, 8'h01);
    total++; if ({q.valid, q.bank_num, q.address, q.data} !== {1'b1, 1'b1, 8'h05, 8'h01})
      begin bad++; $display("FAIL order_first: got %b/%b/%h/%h want 1/1/05/01", q.valid, q.bank_num, q.address, q.data); end
    host_write(2'd1, 8'h03);  // first entry transfers at this edge
    total++; if (q.valid !== 1'b0) begin bad++; $display("FAIL gap_idle1: got valid %b want 0", q.valid); end
    tick();
    total++; if (q.valid !== 1'b0) begin bad++; $display("FAIL gap_idle2: got valid %b want 0", q.valid); end
    tick();
    total++; if ({q.valid, q.bank_num, q.address, q.data} !== {1'b1, 1'b1, 8'h05, 8'h03})
      begin bad++; $display("FAIL order_second: got %b/%b/%h/%h want 1/1/05/03", q.valid, q.bank_num, q.address, q.data); end
    tick();
    total++; if (q.valid !== 1'b0) begin bad++; $display("FAIL order_drained: got valid %b want 0", q.valid); end
    tick(); tick(); tick();
  endtask

  task automatic test_overflow();
    int n;
    ready = 1'b0;
    host_write(2'd0, 8'h10);
    for (int i = 0; i < 4; i++) host_write(2'd1, 8'(8'hA0 + i));
    total++; if (fifo_overflow !== 1'b0) begin bad++; $display("FAIL ovf_at4: got %b want 0", fifo_overflow); end
    host_write(2'd1, 8'hA4);
    total++; if (fifo_overflow !== 1'b1) begin bad++; $display("FAIL ovf_at5: got %b want 1", fifo_overflow); end
    tick();
    total++; if ({q.valid, q.address, q.data} !== {1'b1, 8'h10, 8'hA0})
      begin bad++; $display("FAIL ovf_hold: got %b/%h/%h want 1/10/a0", q.valid, q.address, q.data); end
    ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (q.valid) begin
        total++; if (q.data !== 8'(8'hA0 + n)) begin bad++; $display("FAIL ovf_drain%0d: got %h want %h", n, q.data, 8'(8'hA0 + n)); end
        n++;
      end
      tick();
    end
    total++; if (n !== 4) begin bad++; $display("FAIL ovf_count: got %0d want 4", n); end
    total++; if (fifo_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", fifo_overflow); end
  endtask

  task automatic test_full_pop();
    int n;
    do_reset();
    ready = 1'b0;
    host_write(2'd0, 8'h30);
    for (int i = 0; i < 4; i++) host_write(2'd1, 8'(8'hB0 + i));
    ready = 1'b1;
    host_write(2'd1, 8'hB4);  // push into full FIFO while head pops
    total++; if (fifo_overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf: got %b want 0", fifo_overflow); end
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (q.valid) begin
        total++; if (q.data !== 8'(8'hB1 + n)) begin bad++; $display("FAIL fullpop_drain%0d: got %h want %h", n, q.data, 8'(8'hB1 + n)); end
        n++;
      end
      tick();
    end
    total++; if (n !== 4) begin bad++; $display("FAIL fullpop_count: got %0d want 4", n); end
  endtask

  task automatic test_status();
    irq_n = 1'b0; ft1 = 1'b1; ft2 = 1'b0;
    host_read(2'd0);
    total++; if (host_dout !== 8'hC0) begin bad++; $display("FAIL status0: got %h want c0", host_dout); end
    irq_n = 1'b1; ft1 = 1'b0;
    tick();
    total++; if (host_dout !== 8'hC0) begin bad++; $display("FAIL status_hold: got %h want c0", host_dout); end
    host_read(2'd0);
    total++; if (host_dout !== 8'h00) begin bad++; $display("FAIL status_clear: got %h want 00", host_dout); end
    host_read(2'd1);
    total++; if (host_dout !== 8'hFF) begin bad++; $display("FAIL status1: got %h want ff", host_dout); end
  endtask

  task automatic test_rd_wr_together();
    ready = 1'b0;
    host_read(2'd0);
    host_address = 2'd3; host_din = 8'h99; host_wr = 1'b1; host_rd = 1'b1;
    tick();
    host_wr = 1'b0; host_rd = 1'b0;
    total++; if (host_dout !== 8'hFF) begin bad++; $display("FAIL rdwr_dout: got %h want ff", host_dout); end
    total++; if ({q.valid, q.address, q.data} !== {1'b1, 8'h30, 8'h99})
      begin bad++; $display("FAIL rdwr_push: got %b/%h/%h want 1/30/99", q.valid, q.address, q.data); end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    host_write(2'd2, 8'h44);
    for (int i = 0; i < 2; i++) host_write(2'd1, 8'(8'hC0 + i));
    do_reset();
    total++; if (q.valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", q.valid); end
    total++; if (host_dout !== 8'h00) begin bad++; $display("FAIL mid_dout: got %h want 00", host_dout); end
    total++; if (fifo_overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf: got %b want 0", fifo_overflow); end
    host_write(2'd1, 8'h77);
    total++; if ({q.valid, q.bank_num, q.address, q.data} !== {1'b1, 1'b0, 8'h00, 8'h77})
      begin bad++; $display("FAIL mid_next: got %b/%b/%h/%h want 1/0/00/77", q.valid, q.bank_num, q.address, q.data); end
    tick();
    total++; if ({q.valid, q.data} !== {1'b1, 8'h77}) begin bad++; $display("FAIL mid_stable: got %b/%h want 1/77", q.valid, q.data); end
  endtask

  initial begin
    ic_n = 1'b0; ready = 1'b0; host_address = 2'd0; host_wr = 1'b0;
    host_rd = 1'b0; host_din = 8'h00; irq_n = 1'b1; ft1 = 1'b0; ft2 = 1'b0;
    test_reset();
    test_single();
    test_order_gap();
    test_overflow();
    test_full_pop();
    test_status();
    test_rd_wr_together();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opl3_host_if.md
Name: opl3_host_if

Overview:
- Host-side front end of the OPL3 core.
- Decodes CPU I/O port accesses (base+0..3) into latched register addresses and data writes.
- Buffers the resulting register writes in a small FIFO and presents them one at a time, as opl3_reg_wr_t, to the downstream register file through a valid/ready handshake with a programmable inter-write gap.
- Also serves status-port reads built from timer flags.

Parameters:
- FIFO_DEPTH, 4: register-write FIFO entries; power of two, ≥2.
- MIN_GAP, 2: idle cycles forced between successive accepted output writes; 0 allows back-to-back transfers.

Ports:
- clk, in, 1: core clock.
- ic_n, in, 1: synchronous, active-low reset.
- host_address, in, 2: port offset (0 = addr bank0, 1 = data, 2 = addr bank1, 3 = data).
- host_wr, in, 1: single-cycle write strobe.
- host_rd, in, 1: single-cycle read strobe.
- host_din, in, 8: write data.
- host_dout, out, 8: registered read data.
- irq_n, in, 1: active-low IRQ from timers.
- ft1, in, 1: timer1 flag.
- ft2, in, 1: timer2 flag.
- opl3_reg_wr, out, opl3_reg_wr_t (18 bits): {valid, bank_num, address, data} to the register file.
- opl3_reg_wr_ready, in, 1: downstream accept.
- fifo_overflow, out, 1: sticky, set when a data write is dropped.

Behaviour:
- Reset (ic_n=0 at a clk edge):
  - FIFO emptied; gap counter 0.
  - Latched address = 0x00; latched bank = 0.
  - host_dout = 0x00; fifo_overflow = 0; opl3_reg_wr.valid = 0.
  - Reset mid-transfer discards all queued entries; no partial write is emitted.
- Address write (host_wr, host_address[0]=0): latched address ← host_din; latched bank ← host_address[1]. Nothing is enqueued.
- Data write (host_wr, host_address[0]=1): push {latched bank, latched address, host_din}.
  - Bank comes from the last address write, not from host_address[1].
  - Latched address and bank are unchanged, so repeated data writes reuse them.
- Push acceptance: accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle. Otherwise the entry is dropped and fifo_overflow ← 1, which clears only on reset.
- host_wr and host_rd together: both are honoured independently.
- Output:
  - opl3_reg_wr.valid = (FIFO not empty) && (gap counter == 0).
  - bank_num, address and data come from the FIFO head.
  - Fields are stable while valid && !ready.
  - When ready is low, the fields hold their value; downstream samples them only when valid is high.
- Transfer: occurs when valid && opl3_reg_wr_ready at a clk edge.
  - Head is popped; gap counter loads MIN_GAP.
  - Counter decrements by 1 each cycle while nonzero.
- Latency: a data write into an empty FIFO with gap 0 at edge N gives valid=1 in cycle N+1 (first edge after the write strobe).
- Ordering: strict FIFO; pointers are log2(FIFO_DEPTH)+1 bits, wrap modulo 2·FIFO_DEPTH; full/empty come from the MSB compare.
- Read (host_rd at edge N): host_dout updates at edge N and holds until the next read.
  - host_address = 0: host_dout = {~irq_n, ft1, ft2, 5'b00000}.
  - Other addresses: host_dout = 0xFF.
- No combinational path from host_* inputs to opl3_reg_wr.

Test Plan:
- Reset, then write addr 0x20 at port 0, data 0x55 at port 1, ready=1 → next cycle valid=1, bank_num=0, address=0x20, data=0x55. Transfer happens; valid stays 0 for 2 cycles.
- Write addr 0x05 at port 2, then data 0x01 at port 3, then data 0x03 at port 1 → two outputs {1,0x05,0x01} and {1,0x05,0x03}, in order, separated by exactly 2 idle cycles with ready=1.
- ready=0: push 5 data writes (FIFO_DEPTH=4) → first 4 retained, fifo_overflow=1. Raise ready → exactly 4 outputs in order, overflow stays 1.
- FIFO full with ready=1 and gap=0, data write in the same cycle as the pop → write accepted, fifo_overflow remains 0, occupancy stays 4.
- irq_n=0, ft1=1, ft2=0, read port 0 → host_dout=0xC0 next cycle. Read port 1 → 0xFF.
- With 3 entries queued, assert ic_n=0 for one cycle → valid=0, host_dout=0x00, overflow=0. A following data write emits bank0/address 0x00.
